// File: rtl/tx_req_wrr_arbiter.sv
// Packet-weighted round-robin arbiter sharing one tx request port among PORTS schedulers,
// with per-port outstanding limits and status routing by the port field of the tag.
module tx_req_wrr_arbiter #(
  parameter int unsigned PORTS             = 4,
  parameter int unsigned QUEUE_INDEX_WIDTH = 8,
  parameter int unsigned REQ_TAG_WIDTH     = 8,
  parameter int unsigned LEN_WIDTH         = 16,
  parameter int unsigned WEIGHT_WIDTH      = 4,
  parameter int unsigned MAX_OUTSTANDING   = 16,
  localparam int unsigned PW               = $clog2(PORTS),
  localparam int unsigned MTW              = REQ_TAG_WIDTH + PW
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           enable,
  input  logic [PORTS*WEIGHT_WIDTH-1:0]  cfg_weight,
  input  logic [PORTS*QUEUE_INDEX_WIDTH-1:0] s_axis_tx_req_queue,
  input  logic [PORTS*REQ_TAG_WIDTH-1:0] s_axis_tx_req_tag,
  input  logic [PORTS-1:0]               s_axis_tx_req_valid,
  output logic [PORTS-1:0]               s_axis_tx_req_ready,
  output logic [QUEUE_INDEX_WIDTH-1:0]   m_axis_tx_req_queue,
  output logic [MTW-1:0]                 m_axis_tx_req_tag,
  output logic                           m_axis_tx_req_valid,
  input  logic                           m_axis_tx_req_ready,
  input  logic [LEN_WIDTH-1:0]           s_axis_tx_req_status_len,
  input  logic [MTW-1:0]                 s_axis_tx_req_status_tag,
  input  logic                           s_axis_tx_req_status_valid,
  output logic [PORTS*LEN_WIDTH-1:0]     m_axis_tx_req_status_len,
  output logic [PORTS*REQ_TAG_WIDTH-1:0] m_axis_tx_req_status_tag,
  output logic [PORTS-1:0]               m_axis_tx_req_status_valid,
  output logic                           status_underflow,
  output logic                           active
);

  localparam int unsigned OW = $clog2(MAX_OUTSTANDING + 1);

  logic [WEIGHT_WIDTH-1:0]      r_credit [PORTS];
  logic [OW-1:0]                r_out    [PORTS];
  logic [PW-1:0]                r_ptr;
  logic                         r_m_valid;
  logic [QUEUE_INDEX_WIDTH-1:0] r_m_queue;
  logic [MTW-1:0]               r_m_tag;
  logic [PORTS*LEN_WIDTH-1:0]   r_st_len;
  logic [PORTS*REQ_TAG_WIDTH-1:0] r_st_tag;
  logic [PORTS-1:0]             r_st_valid;
  logic                         r_underflow;

  logic [WEIGHT_WIDTH-1:0] w_weight [PORTS];
  logic [PORTS-1:0]        w_base, w_cur, w_elig, w_inc, w_dec, w_out_nz;
  logic                    w_load_ok, w_slot, w_reload, w_found, w_grant;
  logic [PW-1:0]           w_gnt_idx, w_st_port;
  logic [WEIGHT_WIDTH-1:0] w_gnt_credit;

  assign w_st_port = s_axis_tx_req_status_tag[MTW-1 -: PW];

  // w_base ignores credit: it is what eligibility would be right after a reload.
  always_comb begin
    for (int p = 0; p < PORTS; p++) begin
      w_weight[p] = cfg_weight[p*WEIGHT_WIDTH +: WEIGHT_WIDTH];
      w_base[p]   = s_axis_tx_req_valid[p] && (w_weight[p] != '0) &&
                    (r_out[p] < OW'(MAX_OUTSTANDING));
      w_cur[p]    = w_base[p] && (r_credit[p] != '0);
      w_out_nz[p] = (r_out[p] != '0);
    end
  end

  assign w_load_ok = !r_m_valid || m_axis_tx_req_ready;
  assign w_slot    = rst_n && enable && w_load_ok;
  assign w_reload  = w_slot && (w_cur == '0) && (w_base != '0);
  assign w_elig    = w_reload ? w_base : w_cur;

  always_comb begin
    logic [PW-1:0] idx;
    idx       = '0;
    w_found   = 1'b0;
    w_gnt_idx = '0;
    for (int i = 0; i < PORTS; i++) begin
      idx = r_ptr + PW'(i);
      if (!w_found && w_elig[idx]) begin
        w_found   = 1'b1;
        w_gnt_idx = idx;
      end
    end
  end

  assign w_grant      = w_slot && w_found;
  assign w_gnt_credit = (w_reload ? w_weight[w_gnt_idx] : r_credit[w_gnt_idx]) -
                        WEIGHT_WIDTH'(1);

  always_comb begin
    s_axis_tx_req_ready = '0;
    for (int p = 0; p < PORTS; p++) begin
      w_inc[p] = w_grant && (w_gnt_idx == PW'(p));
      w_dec[p] = s_axis_tx_req_status_valid && (w_st_port == PW'(p)) && w_out_nz[p];
    end
    if (w_grant) s_axis_tx_req_ready[w_gnt_idx] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr       <= '0;
      r_underflow <= 1'b0;
      for (int p = 0; p < PORTS; p++) begin
        r_credit[p] <= '0;
        r_out[p]    <= '0;
      end
    end else begin
      for (int p = 0; p < PORTS; p++) begin
        if (w_reload) r_credit[p] <= w_weight[p];
        if (w_inc[p] && !w_dec[p]) r_out[p] <= r_out[p] + OW'(1);
        else if (w_dec[p] && !w_inc[p]) r_out[p] <= r_out[p] - OW'(1);
      end
      if (w_grant) begin
        r_credit[w_gnt_idx] <= w_gnt_credit;
        r_ptr <= (w_gnt_credit == '0) ? w_gnt_idx + PW'(1) : w_gnt_idx;
      end
      if (s_axis_tx_req_status_valid && !w_out_nz[w_st_port]) r_underflow <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_m_valid <= 1'b0;
      r_m_queue <= '0;
      r_m_tag   <= '0;
    end else if (w_grant) begin
      r_m_valid <= 1'b1;
      r_m_queue <= s_axis_tx_req_queue[w_gnt_idx*QUEUE_INDEX_WIDTH +: QUEUE_INDEX_WIDTH];
      r_m_tag   <= {w_gnt_idx, s_axis_tx_req_tag[w_gnt_idx*REQ_TAG_WIDTH +: REQ_TAG_WIDTH]};
    end else if (w_load_ok) begin
      r_m_valid <= 1'b0;
    end
  end

  // Only the addressed port's tag/len change; the others keep their last value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_st_valid <= '0;
      r_st_tag   <= '0;
      r_st_len   <= '0;
    end else begin
      r_st_valid <= '0;
      if (s_axis_tx_req_status_valid) begin
        r_st_valid[w_st_port] <= 1'b1;
        r_st_tag[w_st_port*REQ_TAG_WIDTH +: REQ_TAG_WIDTH] <=
          s_axis_tx_req_status_tag[REQ_TAG_WIDTH-1:0];
        r_st_len[w_st_port*LEN_WIDTH +: LEN_WIDTH] <= s_axis_tx_req_status_len;
      end
    end
  end

  assign m_axis_tx_req_valid        = r_m_valid;
  assign m_axis_tx_req_queue        = r_m_queue;
  assign m_axis_tx_req_tag          = r_m_tag;
  assign m_axis_tx_req_status_valid = r_st_valid;
  assign m_axis_tx_req_status_tag   = r_st_tag;
  assign m_axis_tx_req_status_len   = r_st_len;
  assign status_underflow           = r_underflow;
  assign active                     = r_m_valid || (w_out_nz != '0);

endmodule

// File: tb/tb_tx_req_wrr_arbiter.sv
// Randomized bench for tx_req_wrr_arbiter against a cycle-level behavioural model.
module tb_tx_req_wrr_arbiter;

  localparam int P = 4, QW = 8, TW = 8, LW = 16, WW = 4, MAXO = 16, MTW = TW + 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           rst_n, en, m_ready, stv_in, underflow, act, m_valid;
  logic [P*WW-1:0] wcfg;
  logic [P*QW-1:0] sq;
  logic [P*TW-1:0] stg;
  logic [P-1:0]   sv, s_ready, st_valid;
  logic [QW-1:0]  m_queue;
  logic [MTW-1:0] m_tag, stag_in;
  logic [LW-1:0]  slen;
  logic [P*LW-1:0] st_len;
  logic [P*TW-1:0] st_tag;

  tx_req_wrr_arbiter #(
    .PORTS(P), .QUEUE_INDEX_WIDTH(QW), .REQ_TAG_WIDTH(TW), .LEN_WIDTH(LW),
    .WEIGHT_WIDTH(WW), .MAX_OUTSTANDING(MAXO)
  ) dut (
    .clk(clk), .rst_n(rst_n), .enable(en), .cfg_weight(wcfg),
    .s_axis_tx_req_queue(sq), .s_axis_tx_req_tag(stg), .s_axis_tx_req_valid(sv),
    .s_axis_tx_req_ready(s_ready), .m_axis_tx_req_queue(m_queue),
    .m_axis_tx_req_tag(m_tag), .m_axis_tx_req_valid(m_valid),
    .m_axis_tx_req_ready(m_ready), .s_axis_tx_req_status_len(slen),
    .s_axis_tx_req_status_tag(stag_in), .s_axis_tx_req_status_valid(stv_in),
    .m_axis_tx_req_status_len(st_len), .m_axis_tx_req_status_tag(st_tag),
    .m_axis_tx_req_status_valid(st_valid), .status_underflow(underflow), .active(act)
  );

  int n_checks = 0, n_fail = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Behavioural model state
  int         m_cred[P], m_out[P], m_ptr;
  bit         m_mv, m_uf;
  logic [QW-1:0]  m_mq;
  logic [MTW-1:0] m_mt;
  logic [P-1:0]   m_stv;
  logic [TW-1:0]  m_stt[P];
  logic [LW-1:0]  m_stl[P];
  bit         c_grant, c_reload, c_load_ok;
  int         c_g, last_g;
  int         gnt_cnt[P];
  logic [MTW-1:0] inflight[$];

  function automatic int wt(int p);
    return int'(wcfg[p*WW +: WW]);
  endfunction

  task automatic model_reset();
    for (int p = 0; p < P; p++) begin
      m_cred[p] = 0; m_out[p] = 0; m_stt[p] = '0; m_stl[p] = '0;
    end
    m_ptr = 0; m_mv = 0; m_uf = 0; m_mq = '0; m_mt = '0; m_stv = '0;
    inflight.delete();
  endtask

  task automatic model_comb();
    bit slot, any_cur, any_base;
    bit base[P];
    c_load_ok = !m_mv || m_ready;
    slot = rst_n && en && c_load_ok;
    any_cur = 0; any_base = 0;
    for (int p = 0; p < P; p++) begin
      base[p] = sv[p] && wt(p) != 0 && m_out[p] < MAXO;
      any_base |= base[p];
      any_cur |= base[p] && m_cred[p] != 0;
    end
    c_reload = slot && !any_cur && any_base;
    c_grant = 0; c_g = 0;
    for (int i = 0; i < P; i++) begin
      int p, ec;
      p = (m_ptr + i) % P;
      ec = c_reload ? wt(p) : m_cred[p];
      if (slot && !c_grant && base[p] && ec > 0) begin
        c_grant = 1; c_g = p;
      end
    end
  endtask

  task automatic model_edge();
    int q;
    logic [1:0] gp;
    if (m_mv && m_ready) inflight.push_back(m_mt);
    q = int'(stag_in[MTW-1 -: 2]);
    for (int p = 0; p < P; p++) begin
      int d, g;
      d = (stv_in && q == p && m_out[p] > 0) ? 1 : 0;
      g = (c_grant && c_g == p) ? 1 : 0;
      if (stv_in && q == p && m_out[p] == 0) m_uf = 1;
      m_out[p] = m_out[p] + g - d;
    end
    m_stv = '0;
    if (stv_in) begin
      m_stv[q] = 1'b1; m_stt[q] = stag_in[TW-1:0]; m_stl[q] = slen;
    end
    if (c_reload) for (int p = 0; p < P; p++) m_cred[p] = wt(p);
    if (c_grant) begin
      gp = c_g[1:0];
      m_cred[c_g]--;
      m_ptr = (m_cred[c_g] > 0) ? c_g : (c_g + 1) % P;
      m_mv = 1; m_mq = sq[c_g*QW +: QW]; m_mt = {gp, stg[c_g*TW +: TW]};
    end else if (c_load_ok) begin
      m_mv = 0;
    end
  endtask

  task automatic check_regs();
    check_eq("m_valid", m_valid, m_mv);
    if (m_mv) begin
      check_eq("m_queue", m_queue, m_mq);
      check_eq("m_tag", m_tag, m_mt);
    end
    check_eq("st_valid", st_valid, m_stv);
    for (int p = 0; p < P; p++) begin
      check_eq("st_tag", st_tag[p*TW +: TW], m_stt[p]);
      check_eq("st_len", st_len[p*LW +: LW], m_stl[p]);
    end
    check_eq("underflow", underflow, m_uf);
    check_eq("active", act, m_mv || m_out[0] + m_out[1] + m_out[2] + m_out[3] != 0);
  endtask

  // Called at a negedge with inputs already applied; returns at the following negedge.
  task automatic step();
    logic [P-1:0] exp_rdy;
    #1;
    model_comb();
    exp_rdy = '0;
    if (c_grant) exp_rdy[c_g] = 1'b1;
    check_eq("s_ready", s_ready, exp_rdy);
    if (c_grant) gnt_cnt[c_g]++;
    last_g = c_grant ? c_g : -1;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_regs();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic rand_payload();
    sq = {$urandom, $urandom};
    stg = $urandom;
  endtask

  int exp1[12] = '{0, 0, 0, 1, 3, 3, 0, 0, 0, 1, 3, 3};

  initial begin
    rst_n = 1'b0; en = 1'b0; m_ready = 1'b1; stv_in = 1'b0; stag_in = '0; slen = '0;
    wcfg = '0; sq = '0; stg = '0; sv = '0;
    model_reset();
    repeat (2) @(negedge clk);
    check_regs();
    check_eq("rst_s_ready", s_ready, 4'b0000);
    rst_n = 1'b1;

    // Weighted order with weights {3,1,0,2}
    wcfg = {4'd2, 4'd0, 4'd1, 4'd3}; sv = 4'hF; en = 1'b1;
    for (int i = 0; i < 12; i++) begin
      rand_payload();
      step();
      check_eq("wrr_order", last_g, exp1[i]);
    end

    // Outstanding limit on port 0
    do_reset();
    wcfg = 16'h000F; sv = 4'b0001;
    for (int p = 0; p < P; p++) gnt_cnt[p] = 0;
    for (int i = 0; i < 20; i++) begin rand_payload(); step(); end
    check_eq("limit_grants", gnt_cnt[0], 16);
    stv_in = 1'b1; stag_in = 10'h005; slen = 16'd100;
    step();
    stv_in = 1'b0;
    repeat (3) step();
    check_eq("limit_regrant", gnt_cnt[0], 17);

    // Status routing to port 2
    do_reset();
    wcfg = 16'h0F00; sv = 4'b0100;
    repeat (3) step();
    sv = '0; stv_in = 1'b1; stag_in = 10'h2A5; slen = 16'd64;
    step();
    stv_in = 1'b0;
    check_eq("route_valid", st_valid, 4'b0100);
    check_eq("route_tag", st_tag[2*TW +: TW], 8'hA5);
    check_eq("route_len", st_len[2*LW +: LW], 16'd64);
    step();

    // Downstream stall
    do_reset();
    wcfg = {4'd2, 4'd0, 4'd1, 4'd3}; sv = 4'hF;
    repeat (3) begin rand_payload(); step(); end
    m_ready = 1'b0;
    repeat (5) begin rand_payload(); step(); end
    m_ready = 1'b1;
    repeat (6) begin rand_payload(); step(); end

    // Randomized traffic with status loopback
    do_reset();
    for (int i = 0; i < 800; i++) begin
      if (i % 100 == 0) wcfg = $urandom;
      rand_payload();
      sv = $urandom;
      en = ($urandom_range(0, 9) != 0);
      m_ready = ($urandom_range(0, 3) != 0);
      stv_in = 1'b0;
      slen = $urandom;
      if (inflight.size() > 0 && $urandom_range(0, 2) == 0) begin
        int idx;
        idx = $urandom_range(0, inflight.size() - 1);
        stag_in = inflight[idx];
        inflight.delete(idx);
        stv_in = 1'b1;
      end else if ($urandom_range(0, 99) == 0) begin
        stag_in = $urandom;
        stv_in = 1'b1;
      end
      step();
    end

    // Asynchronous reset mid-burst
    stv_in = 1'b0; en = 1'b1; m_ready = 1'b1; sv = 4'hF; wcfg = {4'd2, 4'd0, 4'd1, 4'd3};
    repeat (5) begin rand_payload(); step(); end
    stv_in = 1'b1; stag_in = 10'h101;
    #2 rst_n = 1'b0;
    #1;
    check_eq("arst_m_valid", m_valid, 1'b0);
    check_eq("arst_s_ready", s_ready, 4'b0000);
    check_eq("arst_active", act, 1'b0);
    check_eq("arst_st_valid", st_valid, 4'b0000);
    check_eq("arst_underflow", underflow, 1'b0);
    model_reset();
    stv_in = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    rand_payload();
    step();
    check_eq("post_rst_first", last_g, 0);
    repeat (4) begin rand_payload(); step(); end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
